// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, ALU and branch codes, operand selects
// and immediate formats used by the decode stage.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_NONE = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef enum logic [1:0] {
        A_RS1,
        A_PC,
        A_ZERO
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2,
        B_IMM,
        B_FOUR
    } b_sel_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational RV32I decoder: ALU op, branch code, operand selects,
// immediate, memory/writeback controls, register usage and illegal flag.
module instr_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [3:0]  o_alu_op,
    output logic [2:0]  o_branch,
    output logic [1:0]  o_a_sel,
    output logic [1:0]  o_b_sel,
    output logic [31:0] o_imm,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [2:0]  o_mem_size,
    output logic        o_is_branch,
    output logic        o_is_jal,
    output logic        o_is_jalr,
    output logic        o_illegal,
    output logic        o_uses_rs1,
    output logic        o_uses_rs2
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7b5;
    imm_fmt_e   w_fmt;
    a_sel_e     w_a_sel;
    b_sel_e     w_b_sel;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_funct7b5 = i_instr[30];

    always_comb begin
        o_alu_op    = ALU_ADD;
        o_branch    = BR_NONE;
        w_a_sel     = A_RS1;
        w_b_sel     = B_IMM;
        w_fmt       = IMM_NONE;
        o_reg_write = 1'b0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_size  = 3'd0;
        o_is_branch = 1'b0;
        o_is_jal    = 1'b0;
        o_is_jalr   = 1'b0;
        o_illegal   = 1'b0;
        o_uses_rs1  = 1'b1;
        o_uses_rs2  = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                o_alu_op = {1'b0, w_funct3};
                if (w_funct7b5 && w_funct3 == 3'b000) o_alu_op = ALU_SUB;
                if (w_funct7b5 && w_funct3 == 3'b101) o_alu_op = ALU_SRA;
                w_b_sel     = B_RS2;
                o_reg_write = 1'b1;
                o_uses_rs2  = 1'b1;
            end
            OPC_OP_IMM: begin
                // No SUBI: bit 30 only selects arithmetic shift
                o_alu_op = {1'b0, w_funct3};
                if (w_funct7b5 && w_funct3 == 3'b101) o_alu_op = ALU_SRA;
                w_fmt       = IMM_I;
                o_reg_write = 1'b1;
            end
            OPC_LOAD: begin
                if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
                    o_illegal = 1'b1;
                end else begin
                    w_fmt       = IMM_I;
                    o_mem_read  = 1'b1;
                    o_reg_write = 1'b1;
                    o_mem_size  = w_funct3;
                end
            end
            OPC_STORE: begin
                if (w_funct3[2] || w_funct3 == 3'b011) begin
                    o_illegal = 1'b1;
                end else begin
                    w_fmt       = IMM_S;
                    o_mem_write = 1'b1;
                    o_mem_size  = w_funct3;
                    o_uses_rs2  = 1'b1;
                end
            end
            OPC_LUI: begin
                w_a_sel     = A_ZERO;
                w_fmt       = IMM_U;
                o_reg_write = 1'b1;
                o_uses_rs1  = 1'b0;
            end
            OPC_AUIPC: begin
                w_a_sel     = A_PC;
                w_fmt       = IMM_U;
                o_reg_write = 1'b1;
                o_uses_rs1  = 1'b0;
            end
            OPC_JAL: begin
                w_a_sel     = A_PC;
                w_b_sel     = B_FOUR;
                w_fmt       = IMM_J;
                o_reg_write = 1'b1;
                o_is_jal    = 1'b1;
                o_uses_rs1  = 1'b0;
            end
            OPC_JALR: begin
                w_b_sel     = B_FOUR;
                w_fmt       = IMM_I;
                o_reg_write = 1'b1;
                o_is_jalr   = 1'b1;
            end
            OPC_BRANCH: begin
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
                    o_illegal = 1'b1;
                end else begin
                    o_branch    = w_funct3;
                    o_is_branch = 1'b1;
                    w_b_sel     = B_RS2;
                    w_fmt       = IMM_B;
                    o_uses_rs2  = 1'b1;
                end
            end
            default: o_illegal = 1'b1;
        endcase

        if (i_instr[11:7] == 5'd0) o_reg_write = 1'b0;
    end

    assign o_a_sel = w_a_sel;
    assign o_b_sel = w_b_sel;
    assign o_imm   = gen_imm(i_instr, w_fmt);

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register with load-use hazard
// detection, bubble insertion, stall hold and branch flush.
module id_ex_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_id_valid,
    input  logic [31:0] if_id_pc,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [3:0]  ex_alu_op,
    output logic [2:0]  ex_branch,
    output logic [31:0] ex_rs2_data,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_is_branch,
    output logic        ex_is_jal,
    output logic        ex_is_jalr,
    output logic        ex_illegal,
    output logic [2:0]  ex_mem_size
);

    logic [3:0]  w_alu_op;
    logic [2:0]  w_branch;
    logic [1:0]  w_a_sel;
    logic [1:0]  w_b_sel;
    logic [31:0] w_imm;
    logic        w_reg_write, w_mem_read, w_mem_write;
    logic [2:0]  w_mem_size;
    logic        w_is_branch, w_is_jal, w_is_jalr, w_illegal;
    logic        w_uses_rs1, w_uses_rs2;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_a, w_b;
    logic        w_hz;

    logic        r_valid;
    logic [31:0] r_pc, r_imm, r_a, r_b, r_rs2_data;
    logic [3:0]  r_alu_op;
    logic [2:0]  r_branch;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic        r_reg_write, r_mem_read, r_mem_write;
    logic        r_is_branch, r_is_jal, r_is_jalr, r_illegal;
    logic [2:0]  r_mem_size;

    instr_decode u_decode (
        .i_instr     (if_id_instr),
        .o_alu_op    (w_alu_op),
        .o_branch    (w_branch),
        .o_a_sel     (w_a_sel),
        .o_b_sel     (w_b_sel),
        .o_imm       (w_imm),
        .o_reg_write (w_reg_write),
        .o_mem_read  (w_mem_read),
        .o_mem_write (w_mem_write),
        .o_mem_size  (w_mem_size),
        .o_is_branch (w_is_branch),
        .o_is_jal    (w_is_jal),
        .o_is_jalr   (w_is_jalr),
        .o_illegal   (w_illegal),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2)
    );

    assign w_rs1 = if_id_instr[19:15];
    assign w_rs2 = if_id_instr[24:20];
    assign w_rd  = if_id_instr[11:7];

    always_comb begin
        case (w_a_sel)
            2'(A_PC):   w_a = if_id_pc;
            2'(A_ZERO): w_a = 32'd0;
            default:    w_a = rs1_data;
        endcase
        case (w_b_sel)
            2'(B_RS2):  w_b = rs2_data;
            2'(B_FOUR): w_b = 32'd4;
            default:    w_b = w_imm;
        endcase
    end

    // A load in ID/EX whose destination the ID instruction reads forces one bubble
    assign w_hz = r_valid && r_mem_read && (r_rd != 5'd0) && if_id_valid &&
                  (((r_rd == w_rs1) && w_uses_rs1) || ((r_rd == w_rs2) && w_uses_rs2));

    assign id_stall = ex_stall | (w_hz & ~flush);

    always_ff @(posedge clk) begin
        if (rst || (!ex_stall && (flush || w_hz || !if_id_valid))) begin
            r_valid     <= 1'b0;
            r_pc        <= 32'd0;
            r_imm       <= 32'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_rs2_data  <= 32'd0;
            r_alu_op    <= ALU_ADD;
            r_branch    <= BR_NONE;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_jal    <= 1'b0;
            r_is_jalr   <= 1'b0;
            r_illegal   <= 1'b0;
            r_mem_size  <= 3'd0;
        end else if (!ex_stall) begin
            r_valid     <= 1'b1;
            r_pc        <= if_id_pc;
            r_imm       <= w_imm;
            r_a         <= w_a;
            r_b         <= w_b;
            r_rs2_data  <= rs2_data;
            r_alu_op    <= w_alu_op;
            r_branch    <= w_branch;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_is_branch <= w_is_branch;
            r_is_jal    <= w_is_jal;
            r_is_jalr   <= w_is_jalr;
            r_illegal   <= w_illegal;
            r_mem_size  <= w_mem_size;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_pc        = r_pc;
    assign ex_imm       = r_imm;
    assign ex_a         = r_a;
    assign ex_b         = r_b;
    assign ex_alu_op    = r_alu_op;
    assign ex_branch    = r_branch;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_rs1       = r_rs1;
    assign ex_rs2       = r_rs2;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_reg_write;
    assign ex_mem_read  = r_mem_read;
    assign ex_mem_write = r_mem_write;
    assign ex_is_branch = r_is_branch;
    assign ex_is_jal    = r_is_jal;
    assign ex_is_jalr   = r_is_jalr;
    assign ex_illegal   = r_illegal;
    assign ex_mem_size  = r_mem_size;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: decode, hazard bubble, flush, stall,
// reset and illegal-instruction scenarios with hand-computed expectations.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_stall;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_a, ex_b, ex_rs2_data;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_branch;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal;
    logic [2:0]  ex_mem_size;

    int checkCount = 0;
    int passCount  = 0;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .id_stall     (id_stall),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_alu_op    (ex_alu_op),
        .ex_branch    (ex_branch),
        .ex_rs2_data  (ex_rs2_data),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_is_branch (ex_is_branch),
        .ex_is_jal    (ex_is_jal),
        .ex_is_jalr   (ex_is_jalr),
        .ex_illegal   (ex_illegal),
        .ex_mem_size  (ex_mem_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge so outputs are sampled mid-cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] r1, input logic [31:0] r2);
        if_id_valid = v;
        if_id_pc    = pc;
        if_id_instr = instr;
        rs1_data    = r1;
        rs2_data    = r2;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h10, 32'h002081B3, 32'd5, 32'd7);
        step();
        step();
        checkCount++;
        if (ex_valid !== 1'b0 || ex_branch !== 3'b010 || ex_a !== 32'd0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0)
            $display("[TB] FAIL reset_state got valid=%b br=%b a=%h rw=%b rd=%0d exp 0/010/0/0/0",
                     ex_valid, ex_branch, ex_a, ex_reg_write, ex_rd);
        else passCount++;
        checkCount++;
        if (id_stall !== 1'b0) $display("[TB] FAIL reset_id_stall got=%b exp=0", id_stall);
        else passCount++;
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(1'b1, 32'h20, 32'h002081B3, 32'd5, 32'd7);
        step();
        checkCount++;
        if (ex_valid !== 1'b1 || ex_alu_op !== 4'd0 || ex_a !== 32'd5 || ex_b !== 32'd7 ||
            ex_rd !== 5'd3 || ex_reg_write !== 1'b1 || ex_branch !== 3'b010 || ex_pc !== 32'h20)
            $display("[TB] FAIL add got v=%b op=%0d a=%h b=%h rd=%0d rw=%b br=%b pc=%h exp 1/0/5/7/3/1/010/20",
                     ex_valid, ex_alu_op, ex_a, ex_b, ex_rd, ex_reg_write, ex_branch, ex_pc);
        else passCount++;
    endtask

    task automatic test_alu_ops();
        drive(1'b1, 32'h24, 32'h402081B3, 32'd1, 32'd2);
        step();
        checkCount++;
        if (ex_alu_op !== 4'd8) $display("[TB] FAIL sub_op got=%0d exp=8", ex_alu_op);
        else passCount++;
        drive(1'b1, 32'h28, 32'h4020D1B3, 32'd1, 32'd2);
        step();
        checkCount++;
        if (ex_alu_op !== 4'd9) $display("[TB] FAIL sra_op got=%0d exp=9", ex_alu_op);
        else passCount++;
        drive(1'b1, 32'h2C, 32'h4030D093, 32'd1, 32'd2);
        step();
        checkCount++;
        if (ex_alu_op !== 4'd9 || ex_imm !== 32'h403 || ex_b !== 32'h403)
            $display("[TB] FAIL srai got op=%0d imm=%h b=%h exp 9/403/403", ex_alu_op, ex_imm, ex_b);
        else passCount++;
        drive(1'b1, 32'h30, 32'h40008213, 32'd1, 32'd2);
        step();
        checkCount++;
        if (ex_alu_op !== 4'd0 || ex_imm !== 32'h400 || ex_rd !== 5'd4)
            $display("[TB] FAIL addi_f7 got op=%0d imm=%h rd=%0d exp 0/400/4", ex_alu_op, ex_imm, ex_rd);
        else passCount++;
        drive(1'b1, 32'h34, 32'h123453B7, 32'hAAAA, 32'hBBBB);
        step();
        checkCount++;
        if (ex_a !== 32'd0 || ex_b !== 32'h12345000 || ex_imm !== 32'h12345000 || ex_reg_write !== 1'b1)
            $display("[TB] FAIL lui got a=%h b=%h imm=%h rw=%b exp 0/12345000/12345000/1", ex_a, ex_b, ex_imm, ex_reg_write);
        else passCount++;
    endtask

    task automatic test_branch();
        drive(1'b1, 32'h100, 32'hFE20ECE3, 32'd3, 32'd9);
        step();
        checkCount++;
        if (ex_branch !== 3'b110 || ex_is_branch !== 1'b1 || ex_imm !== 32'hFFFFFFF8 ||
            ex_reg_write !== 1'b0 || ex_a !== 32'd3 || ex_b !== 32'd9)
            $display("[TB] FAIL bltu got br=%b isb=%b imm=%h rw=%b a=%h b=%h exp 110/1/fffffff8/0/3/9",
                     ex_branch, ex_is_branch, ex_imm, ex_reg_write, ex_a, ex_b);
        else passCount++;
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h200, 32'h0000A283, 32'h1000, 32'd0);
        step();
        checkCount++;
        if (ex_mem_read !== 1'b1 || ex_rd !== 5'd5 || ex_mem_size !== 3'd2 || ex_a !== 32'h1000 || ex_b !== 32'd0)
            $display("[TB] FAIL lw got mr=%b rd=%0d sz=%0d a=%h b=%h exp 1/5/2/1000/0", ex_mem_read, ex_rd, ex_mem_size, ex_a, ex_b);
        else passCount++;
        drive(1'b1, 32'h204, 32'h00228333, 32'd11, 32'd22);
        checkCount++;
        if (id_stall !== 1'b1) $display("[TB] FAIL hz_stall got=%b exp=1", id_stall);
        else passCount++;
        step();
        checkCount++;
        if (ex_valid !== 1'b0 || ex_branch !== 3'b010 || id_stall !== 1'b0)
            $display("[TB] FAIL hz_bubble got v=%b br=%b stall=%b exp 0/010/0", ex_valid, ex_branch, id_stall);
        else passCount++;
        step();
        checkCount++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_a !== 32'd11 || ex_b !== 32'd22 || ex_pc !== 32'h204)
            $display("[TB] FAIL hz_issue got v=%b rd=%0d a=%h b=%h pc=%h exp 1/6/b/16/204", ex_valid, ex_rd, ex_a, ex_b, ex_pc);
        else passCount++;
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h208, 32'h0000A283, 32'h1000, 32'd0);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h20C, 32'h00228333, 32'd1, 32'd2);
        checkCount++;
        if (id_stall !== 1'b0) $display("[TB] FAIL flush_hz_stall got=%b exp=0", id_stall);
        else passCount++;
        step();
        checkCount++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0) $display("[TB] FAIL flush_hz_bubble got v=%b rd=%0d exp 0/0", ex_valid, ex_rd);
        else passCount++;
        drive(1'b1, 32'h40, 32'h010000EF, 32'd0, 32'd0);
        step();
        checkCount++;
        if (ex_valid !== 1'b0 || ex_is_jal !== 1'b0 || ex_branch !== 3'b010)
            $display("[TB] FAIL flush_jal got v=%b jal=%b br=%b exp 0/0/010", ex_valid, ex_is_jal, ex_branch);
        else passCount++;
        flush = 1'b0;
        drive(1'b1, 32'h40, 32'h010000EF, 32'd0, 32'd0);
        step();
        checkCount++;
        if (ex_valid !== 1'b1 || ex_a !== 32'h40 || ex_b !== 32'd4 || ex_alu_op !== 4'd0 ||
            ex_is_jal !== 1'b1 || ex_imm !== 32'd16 || ex_rd !== 5'd1 || ex_reg_write !== 1'b1)
            $display("[TB] FAIL jal got v=%b a=%h b=%h op=%0d jal=%b imm=%h rd=%0d rw=%b exp 1/40/4/0/1/10/1/1",
                     ex_valid, ex_a, ex_b, ex_alu_op, ex_is_jal, ex_imm, ex_rd, ex_reg_write);
        else passCount++;
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h300, 32'h002081B3, 32'd5, 32'd7);
        step();
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h304 + 32'(i * 4), 32'h402081B3 + 32'(i << 7), 32'(i + 40), 32'(i + 50));
            checkCount++;
            if (id_stall !== 1'b1) $display("[TB] FAIL stall_id_stall cyc=%0d got=%b exp=1", i, id_stall);
            else passCount++;
            step();
            checkCount++;
            if (ex_valid !== 1'b1 || ex_a !== 32'd5 || ex_b !== 32'd7 || ex_rd !== 5'd3 ||
                ex_alu_op !== 4'd0 || ex_pc !== 32'h300)
                $display("[TB] FAIL stall_hold cyc=%0d got v=%b a=%h b=%h rd=%0d op=%0d pc=%h exp 1/5/7/3/0/300",
                         i, ex_valid, ex_a, ex_b, ex_rd, ex_alu_op, ex_pc);
            else passCount++;
        end
        rst = 1'b1; flush = 1'b1;
        step();
        checkCount++;
        if (ex_valid !== 1'b0 || ex_a !== 32'd0 || ex_branch !== 3'b010)
            $display("[TB] FAIL reset_mid_stall got v=%b a=%h br=%b exp 0/0/010", ex_valid, ex_a, ex_branch);
        else passCount++;
        rst = 1'b0; flush = 1'b0; ex_stall = 1'b0;
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h400, 32'h0000007F, 32'd1, 32'd2);
        step();
        checkCount++;
        if (ex_valid !== 1'b1 || ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0)
            $display("[TB] FAIL illegal_opc got v=%b ill=%b rw=%b mr=%b exp 1/1/0/0", ex_valid, ex_illegal, ex_reg_write, ex_mem_read);
        else passCount++;
        drive(1'b1, 32'h404, 32'h00002063, 32'd1, 32'd2);
        step();
        checkCount++;
        if (ex_illegal !== 1'b1 || ex_is_branch !== 1'b0 || ex_branch !== 3'b010)
            $display("[TB] FAIL illegal_br got ill=%b isb=%b br=%b exp 1/0/010", ex_illegal, ex_is_branch, ex_branch);
        else passCount++;
        drive(1'b0, 32'h408, 32'h002081B3, 32'd1, 32'd2);
        step();
        checkCount++;
        if (ex_valid !== 1'b0 || ex_illegal !== 1'b0) $display("[TB] FAIL invalid_bubble got v=%b ill=%b exp 0/0", ex_valid, ex_illegal);
        else passCount++;
    endtask

    initial begin
        rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
        if_id_valid = 1'b0; if_id_pc = 32'd0; if_id_instr = 32'd0;
        rs1_data = 32'd0; rs2_data = 32'd0;
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_load_use();
        test_flush();
        test_stall();
        test_illegal();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
